// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, LSB first,
//   one bit per clock. A single full-subtractor cell and a borrow flop do the
//   arithmetic. A start/busy/done handshake sequences each operation. The
//   result is registered and held until the next operation completes.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed overflow output.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request, sampled only while idle
//   a         in   WIDTH  minuend, captured on accepted start
//   b         in   WIDTH  subtrahend, captured on accepted start
//   bin       in   1      borrow-in, captured on accepted start
//   busy      out  1      high while bits are being processed
//   done      out  1      one-cycle pulse: diff/bout (and overflow) valid
//   diff      out  WIDTH  a - b - bin modulo 2^WIDTH
//   bout      out  1      borrow-out, 1 iff a < b + bin (unsigned)
//   overflow  out  1      signed overflow (SERIAL_SUB_OVF_EN only)
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell on the current LSBs.
  logic d_bit;
  logic brw_next;
  assign d_bit    = a_sh[0] ^ b_sh[0] ^ brw;
  assign brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);

  assign busy = (state == S_RUN);

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are needed after the shift registers have consumed them.
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (state == S_DONE)
        overflow <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Result fills from the MSB end so it is aligned after WIDTH shifts.
          res  <= {d_bit, res[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= brw_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST)
            state <= S_DONE;
        end
        S_DONE: begin
          diff  <= res;
          bout  <= brw;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic one bit wider than the operands.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic bi);
    int unsigned t;
    logic [W-1:0] dv;
    logic         bo;
    logic         ov;
    t  = int'(x) - int'(y) - int'(bi);
    dv = W'(t);
    bo = (int'(x) < int'(y) + int'(bi));
    ov = (x[W-1] != y[W-1]) && (dv[W-1] != x[W-1]);
    return {ov, bo, dv};
  endfunction

  // One operation; optionally scrambles inputs and pulses start during RUN.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                       input bit noise);
    logic [W+1:0] e;
    int n, busy_cnt, both;
    e = ref_sub(ta, tb_, tbin);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; both = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 3 * W; i++) begin
      if (noise) begin
        start = (i < W - 1);
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      @(posedge clk); #1;
      if (busy && done) both++;
      if (busy) busy_cnt++;
      if (done) begin n = i; break; end
    end
    start = 1'b0;
    chk("latency", n, W + 1);
    chk("busy_cycles", busy_cnt, W);
    chk("busy_done_overlap", both, 0);
    chk("diff", diff, e[W-1:0]);
    chk("bout", bout, e[W]);
`ifdef SERIAL_SUB_OVF_EN
    chk("overflow", overflow, e[W+1]);
`endif
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    chk("diff_hold", diff, e[W-1:0]);
  endtask

  initial begin
    int t1, t2, seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_overflow", overflow, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the reference scenarios.
    do_op(8'd81, 8'd18, 1'b1, 1'b0);
    chk("t1_diff", diff, 62);
    do_op(8'd5, 8'd6, 1'b1, 1'b0);
    chk("t2_diff", diff, 254);
    chk("t2_bout", bout, 1);
    do_op(8'd200, 8'd152, 1'b0, 1'b1);
    chk("t3_diff", diff, 48);
    do_op(8'd0, 8'd0, 1'b1, 1'b0);
    chk("t4_diff", diff, 255);
    chk("t4_bout", bout, 1);

    // Back-to-back with start held high.
    a = 8'd0; b = 8'd0; bin = 1'b1; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    start = 1'b0;
    chk("b2b_spacing", t2 - t1, 10);
    chk("b2b_diff", diff, 255);
    repeat (W + 3) @(posedge clk);
    #1;

    // Reset in the middle of a run.
    a = 8'd46; b = 8'd34; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort_no_activity", seen, 0);
    do_op(8'd46, 8'd34, 1'b0, 1'b0);
    chk("t5_diff", diff, 12);

`ifdef SERIAL_SUB_OVF_EN
    do_op(8'h80, 8'h01, 1'b0, 1'b0);
    chk("t6_diff", diff, 8'h7F);
    chk("t6_ovf", overflow, 1);
    do_op(8'h10, 8'h01, 1'b0, 1'b0);
    chk("t6b_ovf", overflow, 0);
`endif

    // Randomized operations, half with noise on the inputs during RUN.
    for (int k = 0; k < 30; k++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'(k % 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
